// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that lends one shared combinational ALU to two requesters
// and returns each result through a registered valid/ready response channel.
module alu_share_ctrl #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [WIDTH-1:0]  a_in1,
    input  logic [WIDTH-1:0]  a_in2,
    input  logic [CTRL_W-1:0] a_control,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [WIDTH-1:0]  b_in1,
    input  logic [WIDTH-1:0]  b_in2,
    input  logic [CTRL_W-1:0] b_control,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [WIDTH-1:0]  alu_in2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_out,
    output logic              resp_zero,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, next_state;
    logic   last_grant;
    logic   op_id;
    logic   grant_b;
    logic   accept;
    logic   ctrl_ok;

    always_comb begin
        ctrl_ok = 1'b0;
        case (alu_control)
            CTRL_W'(4'b0000),
            CTRL_W'(4'b0001),
            CTRL_W'(4'b0010),
            CTRL_W'(4'b0110),
            CTRL_W'(4'b0111): ctrl_ok = 1'b1;
            default:          ctrl_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        next_state = state;
        grant_b    = 1'b0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_b = ~last_grant;
                end else begin
                    grant_b = b_valid;
                end
                a_ready = a_valid && !grant_b;
                b_ready = b_valid && grant_b;
                if (a_ready || b_ready) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign accept = a_ready || b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= '0;
            op_id       <= 1'b0;
            last_grant  <= 1'b1;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_out    <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_in1     <= b_ready ? b_in1 : a_in1;
                alu_in2     <= b_ready ? b_in2 : a_in2;
                alu_control <= b_ready ? b_control : a_control;
                op_id       <= b_ready;
                last_grant  <= b_ready;
            end
            // Unsupported codes never expose whatever the ALU happened to produce.
            if (state == EXEC) begin
                resp_valid <= 1'b1;
                resp_id    <= op_id;
                if (ctrl_ok) begin
                    resp_out  <= alu_out;
                    resp_zero <= alu_zero;
                    resp_err  <= 1'b0;
                end else begin
                    resp_out  <= '0;
                    resp_zero <= 1'b0;
                    resp_err  <= 1'b1;
                end
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences the single shared 32-bit ALU between two requesters, A and B.
- Typical requesters: the EX-stage datapath and a multi-cycle helper unit such as a branch comparator or address unit.
- Round-robin arbitration; operands and control are latched before they drive the ALU.
- The ALU result is captured into a registered response channel with a valid/ready handshake.
- Unsupported control codes are rejected with an error flag; the ALU result is not used for them.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU control width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has an op.
- a_ready  out  1  A's op accepted this cycle.
- a_in1  in  WIDTH  A operand 1.
- a_in2  in  WIDTH  A operand 2.
- a_control  in  CTRL_W  A ALU control.
- b_valid, b_ready, b_in1, b_in2, b_control: same as A, for requester B.
- alu_in1  out  WIDTH  to ALU in1.
- alu_in2  out  WIDTH  to ALU in2.
- alu_control  out  CTRL_W  to ALU control.
- alu_out  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_id  out  1  0 = A, 1 = B.
- resp_out  out  WIDTH  registered result.
- resp_zero  out  1  registered zero flag.
- resp_err  out  1  unsupported control code.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs:
  - resp_valid=0, resp_id=0, resp_out=0, resp_zero=0, resp_err=0.
  - alu_in1=0, alu_in2=0, alu_control=4'b0000.
  - last_grant=1, so A wins the first tie.
- Supported control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
  - Any other code is invalid.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = A if a_valid and not b_valid.
  - grant = B if b_valid and not a_valid.
  - If both are valid, grant = the requester that is not last_grant.
  - a_ready/b_ready are combinational: high only in IDLE and only for the granted requester. Never both high.
  - On valid&ready: latch in1/in2/control into the alu_* registers, latch id, set last_grant=id, go to EXEC.
- EXEC (exactly one cycle; the ALU is combinational):
  - alu_* are held stable.
  - At the edge: resp_out<=alu_out, resp_zero<=alu_zero, resp_id<=id, resp_err<=0, resp_valid<=1; go to RESP.
  - If the latched control is invalid: resp_out<=0, resp_zero<=0, resp_err<=1 instead.
- RESP:
  - resp_* are held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid&resp_ready: resp_valid<=0, go to IDLE.
  - No new request is accepted in RESP; a_ready=b_ready=0.
- Latency: accept at edge k → resp_valid high after edge k+1.
- Minimum spacing between accepts is 3 cycles: accept, EXEC, RESP with resp_ready=1, then IDLE accepts again.
- alu_* keep the last op's values outside EXEC. They are only guaranteed meaningful during EXEC.
- Requesters must hold valid and operands stable until ready. A requester dropping valid before ready is legal; no grant occurs for it.
- A requester that remains valid after its accept is treated as a new op.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded. No response is produced and the reset values above apply immediately.
- No arithmetic is performed in this block. Width matching is the ALU's responsibility. resp_out is a straight copy of alu_out.

Test Plan:
1. After reset, A only: a_in1=21, a_in2=12, a_control=0010, resp_ready=1 → a_ready=1 in cycle 0; resp_valid high after edge 2 with resp_out=33, resp_zero=0, resp_id=0, resp_err=0; IDLE after edge 3.
2. Both valid from reset: A 21 AND 12 (0000), B 21 OR 12 (0001) → A served first (resp_out=4, id=0); B served next (resp_out=29, id=1). Then with both re-asserted, A is granted (last_grant=B).
3. B: in1=12, in2=12, control=0110 → resp_out=0, resp_zero=1. Then B: in1=12, in2=21, control=0111 → resp_out=1, resp_zero=0.
4. A: control=1111 → resp_err=1, resp_out=0, resp_zero=0, same latency as a valid op; the next valid op has resp_err=0.
5. Backpressure: hold resp_ready=0 for 4 cycles → resp_valid and resp_out are stable; a_ready=b_ready=0 despite both being valid; release resp_ready → IDLE and accept on the following cycle.
6. Reset asserted asynchronously mid-cycle during EXEC → resp_valid=0 and alu_control=0000 immediately; no response is ever produced for that op; A wins the first tie after reset.
